// File: rtl/cnt_mod.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_mod
//  Brief    : Parametrised modulo counter with up/down direction, synchronous
//             parallel load, enable prescaler and wrap / one-shot modes.
//             out_pulse marks every terminal event for one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module cnt_mod #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             out_pulse,
    output logic             done,
    output logic             tick
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] c_mod_max  = WIDTH'(MOD_MAX);
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PRESCALE - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out,   w_out_nxt;
    logic [PRE_W-1:0] r_pre,   w_pre_nxt;
    logic             r_pulse, w_pulse_nxt;
    logic             r_done,  w_done_nxt;
    logic             w_tick;
    logic             w_term;
    logic [WIDTH-1:0] w_load_clamped;

    // Step strobe: last enabled prescale cycle while running; suppressed in reset.
    assign w_tick = ~reset & en & (r_state == ST_RUN) & (r_pre == c_pre_last);

    // Terminal value depends on the direction sampled at the step.
    assign w_term = up ? (r_out == c_mod_max) : (r_out == '0);

    // Loaded values beyond the terminal value saturate to it.
    assign w_load_clamped = (load_val > c_mod_max) ? c_mod_max : load_val;

    // Next-state logic: load wins over a coincident step; steps only on tick.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_pre_nxt   = r_pre;
        w_pulse_nxt = 1'b0;
        w_done_nxt  = r_done;
        if (load) begin
            w_out_nxt   = w_load_clamped;
            w_pre_nxt   = '0;
            w_state_nxt = ST_RUN;
            w_done_nxt  = 1'b0;
        end else if (en && (r_state == ST_RUN)) begin
            if (w_tick) begin
                w_pre_nxt = '0;
                if (w_term) begin
                    w_pulse_nxt = 1'b1;
                    if (oneshot) begin
                        w_state_nxt = ST_HALT;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_out_nxt = up ? '0 : c_mod_max;
                    end
                end else begin
                    w_out_nxt = up ? (r_out + WIDTH'(1)) : (r_out - WIDTH'(1));
                end
            end else begin
                w_pre_nxt = r_pre + PRE_W'(1);
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_out   <= '0;
            r_pre   <= '0;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_pre   <= w_pre_nxt;
            r_pulse <= w_pulse_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign out       = r_out;
    assign out_pulse = r_pulse;
    assign done      = r_done;
    assign tick      = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_cnt_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnt_mod
//  Brief    : Randomised self-checking bench for cnt_mod. Several instances
//             with different MOD_MAX / PRESCALE share one stimulus stream and
//             are compared each cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cnt_mod;

    localparam int N      = 5;
    localparam int CYCLES = 4000;

    function automatic int mod_of(input int g);
        case (g)
            0:       return 255;
            1:       return 9;
            2:       return 5;
            3:       return 9;
            default: return 1;
        endcase
    endfunction

    function automatic int pre_of(input int g);
        case (g)
            1:       return 4;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       reset, en, up, oneshot, load;
    logic [7:0] load_val;

    logic [7:0] out_a   [N];
    logic       pulse_a [N];
    logic       done_a  [N];
    logic       tick_a  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        cnt_mod #(
            .WIDTH    (8),
            .MOD_MAX  (64'(mod_of(g))),
            .PRESCALE (pre_of(g))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .up        (up),
            .oneshot   (oneshot),
            .load      (load),
            .load_val  (load_val),
            .out       (out_a[g]),
            .out_pulse (pulse_a[g]),
            .done      (done_a[g]),
            .tick      (tick_a[g])
        );
    end

    // Behavioural model: count value, enabled cycles still to wait before the
    // next step, and whether the counter is parked after a one-shot event.
    int m_cnt   [N];
    int m_wait  [N];
    bit m_halt  [N];
    bit m_pulse [N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int mx;
            mx = mod_of(i);
            m_pulse[i] = 1'b0;
            if (reset) begin
                m_cnt[i]  = 0;
                m_wait[i] = pre_of(i);
                m_halt[i] = 1'b0;
            end else if (load) begin
                m_cnt[i]  = (int'(load_val) > mx) ? mx : int'(load_val);
                m_wait[i] = pre_of(i);
                m_halt[i] = 1'b0;
            end else if (en && !m_halt[i]) begin
                if (m_wait[i] > 1) begin
                    m_wait[i]--;
                end else begin
                    m_wait[i] = pre_of(i);
                    if ((up && m_cnt[i] == mx) || (!up && m_cnt[i] == 0)) begin
                        m_pulse[i] = 1'b1;
                        if (oneshot) m_halt[i] = 1'b1;
                        else         m_cnt[i] = up ? 0 : mx;
                    end else begin
                        m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            bit exp_tick;
            exp_tick = !reset && en && !m_halt[i] && (m_wait[i] == 1);
            chk($sformatf("out[%0d]", i),   longint'(out_a[i]),   longint'(m_cnt[i]));
            chk($sformatf("pulse[%0d]", i), longint'(pulse_a[i]), longint'(m_pulse[i]));
            chk($sformatf("done[%0d]", i),  longint'(done_a[i]),  longint'(m_halt[i]));
            chk($sformatf("tick[%0d]", i),  longint'(tick_a[i]),  longint'(exp_tick));
        end
    endtask

    int en_off_left = 0;

    // Directed start (reset, then free upward count) followed by biased random traffic.
    task automatic drive(input int c);
        if (c < 3) begin
            reset = 1'b1; en = 1'b0; up = 1'b1; oneshot = 1'b0; load = 1'b0;
            load_val = 8'd0;
        end else if (c < 400) begin
            reset = 1'b0; en = 1'b1; up = 1'b1; oneshot = 1'b0; load = 1'b0;
        end else begin
            reset    = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = 8'($urandom);
            if (en_off_left > 0) begin
                en_off_left--;
                en = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                en_off_left = 9;
                en = 1'b0;
            end else begin
                en = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 39) == 0) up = ~up;
            if ($urandom_range(0, 59) == 0) oneshot = ~oneshot;
        end
    endtask

    initial begin
        drive(0);
        for (int c = 1; c < CYCLES; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            drive(c);
            @(negedge clk);
            check_all();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnt_mod.md
# cnt_mod

Parametrised modulo counter with selectable count direction, synchronous parallel load, enable prescaler and wrap / one-shot modes. It is the generalised successor to the fixed 8-bit free-running counter with wrap pulse. It serves as the shared timebase/event counter for timers, baud dividers and frame counters. A single-cycle `out_pulse` marks every terminal event.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits (2..32).
- `MOD_MAX`, 2**WIDTH-1: terminal value; count range is 0..MOD_MAX (MOD_MAX ≥ 1, ≤ 2**WIDTH-1).
- `PRESCALE`, 1: number of enabled cycles per count step (1..65535).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: count enable; also gates the prescaler.
- `up` in 1: 1 = count up, 0 = count down; sampled per step.
- `oneshot` in 1: 0 = wrap mode, 1 = stop at terminal.
- `load` in 1: synchronous parallel load strobe.
- `load_val` in WIDTH: value for load.
- `out` out WIDTH: current count.
- `out_pulse` out 1: one-cycle terminal-event pulse.
- `done` out 1: sticky flag; high while halted in one-shot mode.
- `tick` out 1: prescaler strobe; high on cycles where a count step occurs.

## Operation
- Priority per edge: `reset` > `load` > step.
- Prescaler `pre_cnt` (ceil(log2 PRESCALE) bits, min 1):
  - Advances only when `en`=1 and state is RUN.
  - `tick` is combinational: `en && state==RUN && pre_cnt==PRESCALE-1`.
  - `pre_cnt` returns to 0 on `tick`.
  - When `en`=0, `pre_cnt` holds its value and is not cleared.
  - PRESCALE=1 gives `tick` = `en` while in RUN.
- Step (on `tick`), up direction:
  - `out` < MOD_MAX: `out`+1.
  - `out` == MOD_MAX: terminal event.
- Step (on `tick`), down direction:
  - `out` > 0: `out`-1.
  - `out` == 0: terminal event.
- Terminal event, wrap mode: `out` goes to 0 (up) or MOD_MAX (down). `out_pulse` is registered high on the same edge.
- Terminal event, one-shot mode: `out` holds its terminal value. `out_pulse` goes high for one cycle, state goes to HALT and `done` goes to 1.
- State machine, two states:
  - RUN to HALT: terminal event with `oneshot`=1.
  - HALT to RUN: `load`=1 or `reset`=1 only. Deasserting `oneshot` or toggling `en` does not leave HALT.
  - In HALT no steps occur and `tick` is 0.
- Load:
  - `out` gets `load_val`, clamped to MOD_MAX if `load_val` > MOD_MAX.
  - `pre_cnt` goes to 0, state goes to RUN, `done` goes to 0.
  - No `out_pulse` is generated, even if the loaded value is terminal.
  - `load` overrides a coincident `tick`; that step is discarded.
- Changes to `up` or `oneshot` mid-count take effect at the next step. No other side effects.

## Timing
- Reset values: `out`=0, `out_pulse`=0, `done`=0, `pre_cnt`=0, state=RUN. `tick`=0 while `reset` is high.
- `out`, `out_pulse` and `done` are registered. Latency is one edge from the sampled `tick` or `load`.
- `out_pulse` is high exactly during the cycle in which `out` shows the post-terminal value:
  - wrap up: 0;
  - wrap down: MOD_MAX;
  - one-shot: the held terminal value.
- Consecutive terminal events are only possible at PRESCALE=1 with MOD_MAX=1 or similar. Each event still gives one distinct pulse cycle.
- With `en` held high, PRESCALE=P: the first step lands on the P-th rising edge after `reset` is released. Steps then follow every P cycles.
- `reset` asserted mid-count or in HALT takes effect on the next edge regardless of `load` or `en`.
- An `en` drop mid-prescale freezes `pre_cnt`. On resume, the step occurs after the remaining cycles only.

## Test plan
- Defaults (8-bit, MOD_MAX=255, P=1), reset 3 cycles then `en`=1, `up`=1 for 256 steps:
  - `out` reads 0..255, then 0;
  - `out_pulse` is high only in the cycle `out` returns to 0;
  - `done` stays 0.
- MOD_MAX=9, P=4, `en` held, up, wrap:
  - `out` increments every 4th cycle; `tick` is high 1 cycle in 4;
  - the pulse coincides with `out`=0 after 9, at cycle 40 after reset.
  - Dropping `en` for 10 cycles mid-prescale delays the next step by exactly 10 cycles.
- Down count, MOD_MAX=9, after loading 2:
  - sequence 2,1,0,9,8;
  - `out_pulse` is high in the cycle `out`=9.
- One-shot up, MOD_MAX=5:
  - `out` reaches 5; the next step keeps `out`=5, with `out_pulse` for 1 cycle and then `done`=1;
  - further `en` causes no change and no pulses;
  - `load` with 0 clears `done` and resumes counting.
- Load clamp and priority, MOD_MAX=9:
  - `load_val`=200 gives `out`=9 with no pulse;
  - `load` coincident with `tick` keeps only the loaded value;
  - `reset` coincident with `load` gives `out`=0.
- Reset mid-operation (`out`=123, `pre_cnt` nonzero, P=3):
  - all outputs and `pre_cnt` go to 0 on the next edge;
  - the next step lands on the 3rd enabled edge after release.
